// File: rtl/mem_access_unit.sv
// Load/store initiator for the byte-addressed 16-bit data memory.
// Optional MEMU_ALIGN_TRAP_EN: fault misaligned words instead of splitting them.
module mem_access_unit #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_store,
  input  logic          req_byte,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_data,
  output logic          resp_fault,
  output logic          mem_w,
  output logic          mem_r,
  output logic          mem_sb,
  output logic [AW-1:0] mem_wa,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic          store_q, store_d;
  logic          byte_q, byte_d;
  logic          signed_q, signed_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
`ifdef MEMU_ALIGN_TRAP_EN
  logic          fault_q, fault_d;
`endif

  logic          mis;
  logic [7:0]    lo;

  assign mis = ~byte_q & addr_q[0];
  assign lo  = mem_rd[7:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef MEMU_ALIGN_TRAP_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      byte_q   <= byte_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef MEMU_ALIGN_TRAP_EN
      fault_q  <= fault_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    byte_d     = byte_q;
    signed_d   = signed_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
`ifdef MEMU_ALIGN_TRAP_EN
    fault_d    = fault_q;
`endif
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_w      = 1'b0;
    mem_r      = 1'b0;
    mem_sb     = 1'b0;
    mem_wa     = '0;
    mem_wd     = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          store_d  = req_store;
          byte_d   = req_byte;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
`ifdef MEMU_ALIGN_TRAP_EN
          fault_d  = 1'b0;
`endif
          state_d  = ACC0;
        end
      end
      ACC0: begin
`ifdef MEMU_ALIGN_TRAP_EN
        if (mis) begin
          fault_d = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else
`endif
        begin
          mem_sb = byte_q | mis;
          mem_wa = addr_q;
          mem_w  = store_q;
          mem_r  = ~store_q;
          mem_wd = (byte_q | mis) ? {8'h00, wdata_q[7:0]} : wdata_q;
          if (!store_q) begin
            if (byte_q && signed_q)
              rdata_d = {{(DW-8){lo[7]}}, lo};
            else if (byte_q || mis)
              rdata_d = {{(DW-8){1'b0}}, lo};
            else
              rdata_d = mem_rd;
          end
          state_d = mis ? ACC1 : RESP;
        end
      end
      ACC1: begin
        mem_sb = 1'b1;
        mem_wa = addr_q + AW'(1);
        mem_w  = store_q;
        mem_r  = ~store_q;
        mem_wd = {8'h00, wdata_q[15:8]};
        if (!store_q)
          rdata_d = {lo, rdata_q[7:0]};
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a reset landing on this edge must cancel the pending write
    mem_w  = mem_w & reset;
    mem_r  = mem_r & reset;
    mem_sb = mem_sb & reset;
  end

  assign resp_data = rdata_q;
`ifdef MEMU_ALIGN_TRAP_EN
  assign resp_fault = fault_q;
`else
  assign resp_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a byte-array memory model.
// Expected responses are queued at request time and popped on resp_valid.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store, req_byte, req_signed;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [15:0] resp_data;
  logic        mem_w, mem_r, mem_sb;
  logic [15:0] mem_wa, mem_wd, mem_rd;

  logic [7:0]  mem [0:65535];
  logic        poke_en;
  logic [15:0] poke_a;
  logic [7:0]  poke_d;

  typedef struct packed {
    logic [15:0] d;
    logic        f;
  } exp_t;
  exp_t sbq[$];

  int          checks = 0;
  int          failures = 0;
  logic [15:0] wa_log [0:7];
  logic        sb_log [0:7];
  int          wa_n;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_byte(req_byte),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_fault(resp_fault),
    .mem_w(mem_w), .mem_r(mem_r), .mem_sb(mem_sb),
    .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always_comb begin
    logic [15:0] a1;
    a1 = mem_wa + 16'd1;
    mem_rd = '0;
    if (mem_r)
      mem_rd = mem_sb ? {8'h00, mem[mem_wa]} : {mem[a1], mem[mem_wa]};
  end

  always @(posedge clk) begin
    if (poke_en)
      mem[poke_a] <= poke_d;
    else if (mem_w) begin
      mem[mem_wa] <= mem_wd[7:0];
      if (!mem_sb) mem[mem_wa + 16'd1] <= mem_wd[15:8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    poke_en = 1'b1;
    poke_a = a;
    poke_d = d;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic drive(input logic st, by, sg, input logic [15:0] a, wd);
    req_valid = 1'b1;
    req_store = st;
    req_byte = by;
    req_signed = sg;
    req_addr = a;
    req_wdata = wd;
  endtask

  task automatic push(input logic [15:0] d, input logic f);
    exp_t e;
    e.d = d;
    e.f = f;
    sbq.push_back(e);
  endtask

  task automatic xact(input string tag, input logic st, by, sg,
                      input logic [15:0] a, wd, ed, input logic ef,
                      input int lat, input int nr, input int hold);
    int n, rc;
    exp_t e;
    push(ed, ef);
    wa_n = 0;
    resp_ready = (hold == 0);
    @(negedge clk);
    check({tag, "_rdy"}, req_ready, 1);
    drive(st, by, sg, a, wd);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 1;
    rc = 0;
    while (!resp_valid && n < 8) begin
      if (mem_r) rc++;
      if (mem_r || mem_w) begin
        wa_log[wa_n] = mem_wa;
        sb_log[wa_n] = mem_sb;
        wa_n++;
      end
      @(posedge clk);
      #1 n++;
    end
    check({tag, "_valid"}, resp_valid, 1);
    e = sbq.pop_front();
    check({tag, "_data"}, resp_data, e.d);
    check({tag, "_fault"}, resp_fault, e.f);
    check({tag, "_lat"}, n, lat);
    check({tag, "_nrd"}, rc, nr);
    if (hold > 0) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0006, 16'h0000);
      push(16'hDEAD, 1'b0);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check({tag, "_hvalid"}, resp_valid, 1);
        check({tag, "_hdata"}, resp_data, e.d);
        check({tag, "_hrdy"}, req_ready, 0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_idle_rdy"}, req_ready, 1);
      check({tag, "_idle_valid"}, resp_valid, 0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      check({tag, "_pend_acc"}, req_ready, 0);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      check({tag, "_pend_valid"}, resp_valid, 1);
      check({tag, "_pend_data"}, resp_data, e.d);
    end
    @(posedge clk);
    #1;
    check({tag, "_done"}, resp_valid, 0);
  endtask

  initial begin
    logic [7:0]  b;
    logic [15:0] ext;
    reset = 1'b0;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_byte = 1'b0;
    req_signed = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    resp_ready = 1'b1;
    poke_en = 1'b0;
    poke_a = '0;
    poke_d = '0;
    poke(16'h0000, 8'hCD);
    poke(16'h0001, 8'h2B);
    poke(16'h0004, 8'h34);
    poke(16'h0005, 8'h12);
    poke(16'h0006, 8'hAD);
    poke(16'h0007, 8'hDE);
    poke(16'h0101, 8'h00);
    poke(16'h0102, 8'h00);
    poke(16'hFFFF, 8'h00);
    check("rst_rdy", req_ready, 1);
    check("rst_resp", {resp_valid, resp_fault, resp_data}, 0);
    check("rst_strb", {mem_w, mem_r, mem_sb}, 0);
    check("rst_bus", {mem_wa, mem_wd}, 0);
    reset = 1'b1;

    xact("ldw4", 0, 0, 0, 16'h0004, 0, 16'h1234, 0, 2, 1, 0);
    xact("ldbs6", 0, 1, 1, 16'h0006, 0, 16'hFFAD, 0, 2, 1, 0);
    xact("ldbu6", 0, 1, 0, 16'h0006, 0, 16'h00AD, 0, 2, 1, 0);
    xact("ldbs5", 0, 1, 1, 16'h0005, 0, 16'h0012, 0, 2, 1, 0);
`ifdef MEMU_ALIGN_TRAP_EN
    xact("ldw5", 0, 0, 0, 16'h0005, 0, 16'h0000, 1, 2, 0, 0);
    xact("stw_ffff", 1, 0, 0, 16'hFFFF, 16'hBEEF, 16'h0000, 1, 2, 0, 0);
    check("mem_ffff", mem[16'hFFFF], 8'h00);
    check("mem_0", mem[16'h0000], 8'hCD);
    xact("ldw0", 0, 0, 0, 16'h0000, 0, 16'h2BCD, 0, 2, 1, 0);
`else
    xact("ldw5", 0, 0, 0, 16'h0005, 0, 16'hAD12, 0, 3, 2, 0);
    check("split_n", wa_n, 2);
    check("split_wa0", wa_log[0], 16'h0005);
    check("split_wa1", wa_log[1], 16'h0006);
    check("split_sb", {sb_log[0], sb_log[1]}, 2'b11);
    xact("stw_ffff", 1, 0, 0, 16'hFFFF, 16'hBEEF, 16'h0000, 0, 3, 0, 0);
    check("wrap_wa1", wa_log[1], 16'h0000);
    check("mem_ffff", mem[16'hFFFF], 8'hEF);
    check("mem_0", mem[16'h0000], 8'hBE);
    xact("ldw0", 0, 0, 0, 16'h0000, 0, 16'h2BBE, 0, 2, 1, 0);
`endif
    xact("hold", 0, 0, 0, 16'h0004, 0, 16'h1234, 0, 2, 1, 5);

    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      ext = {{8{b[7]}}, b};
      xact("stb", 1, 1, 1, 16'h0200 + 16'(i), {8'($urandom), b},
           16'h0000, 0, 2, 0, 0);
      check("stb_mem", mem[16'h0200 + 16'(i)], b);
      xact("ldb", 0, 1, 1, 16'h0200 + 16'(i), 0, ext, 0, 2, 1, 0);
    end

`ifdef MEMU_ALIGN_TRAP_EN
    xact("st101", 1, 0, 0, 16'h0101, 16'h5566, 16'h0000, 1, 2, 0, 0);
    check("trap_m101", mem[16'h0101], 8'h00);
    check("trap_m102", mem[16'h0102], 8'h00);
`else
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 16'h0101, 16'h5566);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("arst_strb", {mem_w, mem_r, mem_sb}, 0);
    check("arst_rdy", req_ready, 1);
    check("arst_valid", resp_valid, 0);
    check("arst_m101", mem[16'h0101], 8'h66);
    check("arst_m102", mem[16'h0102], 8'h00);
    reset = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      repeat (4) begin
        @(posedge clk);
        #1 seen = seen | resp_valid;
      end
      check("arst_noresp", seen, 0);
    end
`endif
    check("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
